// File: rtl/sync_fifo_pkg.sv
// Shared constants, types and pointer-status helper for the synchronous FIFO.
package sync_fifo_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 4;
   localparam int unsigned ADDR_WIDTH_DEF = 4;

   // Pointer carries one extra wrap bit above the address.
   typedef logic [ADDR_WIDTH_DEF:0]     ptr_t;
   typedef logic [DATA_WIDTH_DEF-1:0]   word_t;

   typedef struct packed {
      logic full;
      logic empty;
   } ptr_flags_t;

   // Full when only the wrap bit differs; empty when the pointers match.
   // Callers zero-extend pointers, so bits above the wrap bit are always equal.
   function automatic ptr_flags_t ptr_status(input logic [31:0] wp,
                                             input logic [31:0] rp,
                                             input int unsigned aw);
      ptr_flags_t  f;
      logic [31:0] wrap_bit;
      wrap_bit = 32'(1) << aw;
      f.full   = ((wp ^ rp) == wrap_bit);
      f.empty  = (wp == rp);
      return f;
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage array with synchronous write and registered read.
module sync_fifo_mem #(
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] w_addr,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] r_addr,
   output logic [DATA_WIDTH-1:0] r_data
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Storage is not reset; stale entries are unreachable until rewritten.
   always_ff @(posedge clk) begin
      if (wr_en) mem[w_addr] <= w_data;
   end

   // Read register holds its value unless a read is accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      r_data <= '0;
      else if (rd_en) r_data <= mem[r_addr];
   end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, registered level flags, occupancy
// count and optional sticky error flags (enabled by SYNC_FIFO_ERR_FLAGS_EN).
module sync_fifo_ctrl
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int unsigned AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
   parameter int unsigned AE_LEVEL   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic                  w_inc,
   output logic                  w_full,
   output logic                  w_almost_full,
   input  logic                  r_inc,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic                  r_empty,
   output logic                  r_almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned PTR_W = ADDR_WIDTH + 1;

   logic [PTR_W-1:0] wptr, rptr;
   logic [PTR_W-1:0] wptr_nxt, rptr_nxt, count_nxt;
   logic             wr_en, rd_en;
   logic             af_nxt, ae_nxt;
   ptr_flags_t       st_nxt;

   // Accept requests against registered flags and derive next-state levels.
   always_comb begin
      wr_en     = w_inc && !w_full;
      rd_en     = r_inc && !r_empty;
      wptr_nxt  = wptr + PTR_W'(wr_en);
      rptr_nxt  = rptr + PTR_W'(rd_en);
      count_nxt = wptr_nxt - rptr_nxt;
      st_nxt    = ptr_status(32'(wptr_nxt), 32'(rptr_nxt), ADDR_WIDTH);
      af_nxt    = 32'(count_nxt) >= AF_LEVEL;
      ae_nxt    = 32'(count_nxt) <= AE_LEVEL;
   end

   // Pointers, count and flags all load from the next-state values together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr           <= '0;
         rptr           <= '0;
         count          <= '0;
         w_full         <= 1'b0;
         r_empty        <= 1'b1;
         w_almost_full  <= 1'b0;
         r_almost_empty <= 1'b1;
      end else begin
         wptr           <= wptr_nxt;
         rptr           <= rptr_nxt;
         count          <= count_nxt;
         w_full         <= st_nxt.full;
         r_empty        <= st_nxt.empty;
         w_almost_full  <= af_nxt;
         r_almost_empty <= ae_nxt;
      end
   end

   sync_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (wr_en),
      .w_addr (wptr[ADDR_WIDTH-1:0]),
      .w_data (w_data),
      .rd_en  (rd_en),
      .r_addr (rptr[ADDR_WIDTH-1:0]),
      .r_data (r_data)
   );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   // Sticky error flags: set on any request against a blocked side, clear only on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= overflow  | (w_inc & w_full);
         underflow <= underflow | (r_inc & r_empty);
      end
   end
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule
